execute_stage_p: RTL

- Parametrised next-generation execute stage for the 5-stage pipeline. Sits between the ID/EX register and the memory stage.
- Adds three things to the combinational ALU path:
  - operand forwarding from EX/MEM and MEM/WB;
  - an extended ALU op set, including an iterative multi-cycle multiplier;
  - a valid/ready handshake with stall and flush.
- Owns the EX/MEM pipeline register internally.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/alu_p.sv | 38 +++
 rtl/execute_stage_p.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared constants and types for the execute stage: ALU op codes, multiplier
// FSM states and operand-forwarding select encoding.
package exec_pkg;

   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_AND = 2;
   localparam int unsigned ALU_OR  = 3;
   localparam int unsigned ALU_XOR = 4;
   localparam int unsigned ALU_SLT = 5;
   localparam int unsigned ALU_SLL = 6;
   localparam int unsigned ALU_SRL = 7;
   localparam int unsigned ALU_MUL = 8;

   typedef enum logic [1:0] {
      IDLE,
      MUL_BUSY,
      MUL_DONE
   } ex_state_e;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_EXMEM,
      FWD_MEMWB
   } fwd_sel_e;

endpackage

// File: rtl/alu_p.sv
// Combinational single-cycle ALU. MUL and undefined codes yield 0 here; the
// multiplier lives in the execute stage's FSM.
module alu_p
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 4
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   localparam int unsigned SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;
   logic            less;

   assign shamt = b[SH_W-1:0];
   assign less  = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      case (op)
         OP_W'(ALU_ADD): result = a + b;
         OP_W'(ALU_SUB): result = a - b;
         OP_W'(ALU_AND): result = a & b;
         OP_W'(ALU_OR):  result = a | b;
         OP_W'(ALU_XOR): result = a ^ b;
         OP_W'(ALU_SLT): result = {{(DATA_W-1){1'b0}}, less};
         OP_W'(ALU_SLL): result = a << shamt;
         OP_W'(ALU_SRL): result = a >> shamt;
         default:        result = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage_p.sv
// Execute stage with EX/MEM and MEM/WB forwarding, an iterative shift-add
// multiplier, valid/ready handshake with flush, and the EX/MEM register.
module execute_stage_p
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned JUMP_W = 11,
   parameter int unsigned OP_W   = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              alu_src,
   input  logic              reg_dst,
   input  logic [OP_W-1:0]   alu_op,
   input  logic              reg_write_in,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] sign_extend,
   input  logic [JUMP_W-1:0] jump_dest_addr,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic              memwb_reg_write,
   input  logic [DATA_W-1:0] memwb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [REG_AW-1:0] reg_dest_out,
   output logic              reg_write_out,
   output logic [JUMP_W-1:0] jump_dest_addr_out,
   output logic              zero_out
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   ex_state_e         state_q, state_d;
   fwd_sel_e          fwd_a, fwd_b;
   logic              load, accept, is_mul;
   logic [DATA_W-1:0] op_a, rt_fwd, op_b, alu_res;
   logic [REG_AW-1:0] dest;

   logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, mul_rt_q;
   logic [CNT_W-1:0]  count_q;
   logic [REG_AW-1:0] mul_dest_q;
   logic              mul_regw_q;
   logic [JUMP_W-1:0] mul_jump_q;

   // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (rs_addr != '0) begin
         if (out_valid && reg_write_out && reg_dest_out == rs_addr) fwd_a = FWD_EXMEM;
         else if (memwb_reg_write && memwb_rd == rs_addr)           fwd_a = FWD_MEMWB;
      end
      if (rt_addr != '0) begin
         if (out_valid && reg_write_out && reg_dest_out == rt_addr) fwd_b = FWD_EXMEM;
         else if (memwb_reg_write && memwb_rd == rt_addr)           fwd_b = FWD_MEMWB;
      end
   end

   always_comb begin
      case (fwd_a)
         FWD_EXMEM: op_a = result_out;
         FWD_MEMWB: op_a = memwb_data;
         default:   op_a = rs_data;
      endcase
      case (fwd_b)
         FWD_EXMEM: rt_fwd = result_out;
         FWD_MEMWB: rt_fwd = memwb_data;
         default:   rt_fwd = rt_data;
      endcase
   end

   assign op_b   = alu_src ? sign_extend : rt_fwd;
   assign dest   = reg_dst ? rd_addr : rt_addr;
   assign is_mul = (alu_op == OP_W'(ALU_MUL));
   assign accept = in_valid & in_ready;

   alu_p #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .op     (alu_op),
      .a      (op_a),
      .b      (op_b),
      .result (alu_res)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (count_q == CNT_W'(1)) state_d = MUL_DONE;
            MUL_DONE: if (load) state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      load     = !out_valid || out_ready;
      in_ready = load && (state_q == IDLE) && !flush;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         mul_rt_q   <= '0;
         mul_dest_q <= '0;
         mul_regw_q <= 1'b0;
         mul_jump_q <= '0;
      end else if (accept && is_mul) begin
         mcand_q    <= op_a;
         mplier_q   <= op_b;
         acc_q      <= '0;
         count_q    <= CNT_W'(DATA_W);
         mul_rt_q   <= rt_fwd;
         mul_dest_q <= dest;
         mul_regw_q <= reg_write_in;
         mul_jump_q <= jump_dest_addr;
      end else if (state_q == MUL_BUSY) begin
         if (mplier_q[0]) acc_q <= acc_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         count_q  <= count_q - CNT_W'(1);
      end
   end

   // A load that does not produce a new result (bubble, MUL start, busy)
   // retires whatever was held so it is not consumed twice.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid          <= 1'b0;
         result_out         <= '0;
         rt_data_out        <= '0;
         reg_dest_out       <= '0;
         reg_write_out      <= 1'b0;
         jump_dest_addr_out <= '0;
         zero_out           <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (state_q == MUL_DONE) begin
         if (load) begin
            out_valid          <= 1'b1;
            result_out         <= acc_q;
            zero_out           <= (acc_q == '0);
            rt_data_out        <= mul_rt_q;
            reg_dest_out       <= mul_dest_q;
            reg_write_out      <= mul_regw_q;
            jump_dest_addr_out <= mul_jump_q;
         end
      end else if (load) begin
         if (accept && !is_mul) begin
            out_valid          <= 1'b1;
            result_out         <= alu_res;
            zero_out           <= (alu_res == '0);
            rt_data_out        <= rt_fwd;
            reg_dest_out       <= dest;
            reg_write_out      <= reg_write_in;
            jump_dest_addr_out <= jump_dest_addr;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
